// File: rtl/btn_conditioner.sv
// Push-button conditioner: per-button 2-flop synchroniser, counter debouncer,
// one-cycle press/release pulses and a software-acknowledged sticky press flag.
module btn_conditioner #(
  parameter int unsigned        NUM_BTN         = 4,
  parameter int unsigned        DEBOUNCE_CYCLES = 1_000_000,
  parameter logic [NUM_BTN-1:0] INVERT_MASK     = '0
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_BTN-1:0] btn_raw,
  input  logic [NUM_BTN-1:0] ack,
  output logic [NUM_BTN-1:0] btn_level,
  output logic [NUM_BTN-1:0] btn_press,
  output logic [NUM_BTN-1:0] btn_release,
  output logic [NUM_BTN-1:0] btn_sticky
);

  localparam int unsigned    CW      = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0]  CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

  logic [NUM_BTN-1:0] in_c;
  logic [NUM_BTN-1:0] sync1, sync2;
  logic [NUM_BTN-1:0] level, press_q, release_q, sticky_q;
  logic [NUM_BTN-1:0] accept;
  logic [CW-1:0]      cnt [NUM_BTN];

  always_comb begin
    in_c = btn_raw ^ INVERT_MASK;
  end

  // A change is accepted on the edge where the disagreeing sample completes the count.
  always_comb begin
    accept = '0;
    for (int unsigned i = 0; i < NUM_BTN; i++) begin
      accept[i] = (sync2[i] != level[i]) && (cnt[i] == CNT_MAX);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1     <= '0;
      sync2     <= '0;
      level     <= '0;
      press_q   <= '0;
      release_q <= '0;
      sticky_q  <= '0;
      for (int unsigned i = 0; i < NUM_BTN; i++) begin
        cnt[i] <= '0;
      end
    end else begin
      sync1     <= in_c;
      sync2     <= sync1;
      level     <= level ^ accept;
      press_q   <= accept & sync2;
      release_q <= accept & ~sync2;
      // Sticky follows the registered press, so an ack seen alongside btn_press loses to the set.
      sticky_q  <= press_q | (sticky_q & ~ack);
      for (int unsigned i = 0; i < NUM_BTN; i++) begin
        if (sync2[i] == level[i] || accept[i]) begin
          cnt[i] <= '0;
        end else begin
          cnt[i] <= cnt[i] + CW'(1);
        end
      end
    end
  end

  assign btn_level   = level;
  assign btn_press   = press_q;
  assign btn_release = release_q;
  assign btn_sticky  = sticky_q;

endmodule

// File: tb/tb_btn_conditioner.sv
// Bench for btn_conditioner: directed scenarios plus random bouncing, checked
// against a streak-counting reference model of the debounce rules.
module tb_btn_conditioner;

  localparam int          D     = 4;
  localparam logic [3:0]  MASK0 = 4'b0000;
  localparam logic [3:0]  MASK1 = 4'b0001;

  logic       clk   = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] raw   = '0, raw_i = '0, ack = '0, ack_i = '0;
  logic [3:0] lvl0, prs0, rel0, stk0;
  logic [3:0] lvl1, prs1, rel1, stk1;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  btn_conditioner #(.NUM_BTN(4), .DEBOUNCE_CYCLES(D), .INVERT_MASK(MASK0)) dut (
    .clk(clk), .rst_n(rst_n), .btn_raw(raw), .ack(ack),
    .btn_level(lvl0), .btn_press(prs0), .btn_release(rel0), .btn_sticky(stk0));

  btn_conditioner #(.NUM_BTN(4), .DEBOUNCE_CYCLES(D), .INVERT_MASK(MASK1)) dut_inv (
    .clk(clk), .rst_n(rst_n), .btn_raw(raw_i), .ack(ack_i),
    .btn_level(lvl1), .btn_press(prs1), .btn_release(rel1), .btn_sticky(stk1));

  // Reference model: inputs reach the debouncer two edges late; a level flips
  // once the delayed input has disagreed with it for D consecutive edges.
  logic [3:0] m_q1 [2], m_q2 [2], m_lvl [2], m_prs [2], m_rel [2], m_stk [2];
  int         m_run [2][4];

  function automatic void model_reset();
    for (int k = 0; k < 2; k++) begin
      m_q1[k] = '0; m_q2[k] = '0; m_lvl[k] = '0;
      m_prs[k] = '0; m_rel[k] = '0; m_stk[k] = '0;
      for (int b = 0; b < 4; b++) m_run[k][b] = 0;
    end
  endfunction

  function automatic void model_step(int k, logic [3:0] in, logic [3:0] a);
    logic [3:0] pr, rl;
    pr = '0; rl = '0;
    for (int b = 0; b < 4; b++) begin
      if (m_q2[k][b] == m_lvl[k][b]) m_run[k][b] = 0;
      else begin
        m_run[k][b] = m_run[k][b] + 1;
        if (m_run[k][b] == D) begin
          m_run[k][b] = 0;
          if (m_q2[k][b]) pr[b] = 1'b1; else rl[b] = 1'b1;
        end
      end
    end
    m_lvl[k] = m_lvl[k] ^ (pr | rl);
    m_stk[k] = m_prs[k] | (m_stk[k] & ~a);
    m_prs[k] = pr;
    m_rel[k] = rl;
    m_q2[k]  = m_q1[k];
    m_q1[k]  = in;
  endfunction

  task automatic chk(string tag, logic [3:0] got, logic [3:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %b expected %b", tag, got, exp);
    end
  endtask

  task automatic tick();
    if (rst_n) begin
      model_step(0, raw ^ MASK0, ack);
      model_step(1, raw_i ^ MASK1, ack_i);
    end
    @(posedge clk);
    #1;
    chk("lvl0", lvl0, m_lvl[0]); chk("prs0", prs0, m_prs[0]);
    chk("rel0", rel0, m_rel[0]); chk("stk0", stk0, m_stk[0]);
    chk("lvl1", lvl1, m_lvl[1]); chk("prs1", prs1, m_prs[1]);
    chk("rel1", rel1, m_rel[1]); chk("stk1", stk1, m_stk[1]);
  endtask

  task automatic ticks(int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic check_zero(string tag);
    chk({tag, "_lvl0"}, lvl0, 4'b0000); chk({tag, "_prs0"}, prs0, 4'b0000);
    chk({tag, "_rel0"}, rel0, 4'b0000); chk({tag, "_stk0"}, stk0, 4'b0000);
    chk({tag, "_lvl1"}, lvl1, 4'b0000); chk({tag, "_prs1"}, prs1, 4'b0000);
  endtask

  // Called just after an edge: assert reset between edges and check it takes effect at once.
  task automatic async_reset();
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    check_zero("async_rst");
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int npress;
    bit found;
    logic [7:0] bseq;
    model_reset();

    // Buttons held through reset: outputs stay 0, then a full-latency press.
    raw = 4'b1111; raw_i = 4'b0001;
    repeat (3) @(posedge clk);
    #1 check_zero("in_rst");
    rst_n = 1'b1;
    for (int e = 1; e <= 7; e++) begin
      tick();
      if (e < 6)  chk("rst_hold_prs_early", prs0, 4'b0000);
      if (e == 6) begin
        chk("rst_hold_prs", prs0, 4'b1111);
        chk("rst_hold_lvl", lvl0, 4'b1111);
        chk("rst_hold_stk_pre", stk0, 4'b0000);
      end
      if (e == 7) begin
        chk("rst_hold_prs_end", prs0, 4'b0000);
        chk("rst_hold_stk", stk0, 4'b1111);
      end
    end
    chk("inv_held_lvl", lvl1, 4'b0000);
    ack = 4'b1111; tick(); ack = '0;
    chk("ack_all", stk0, 4'b0000);
    raw = '0; ticks(8);

    // Clean press and release on bit 1.
    raw = 4'b0010;
    for (int e = 1; e <= 7; e++) begin
      tick();
      if (e < 6)  chk("b1_lvl_early", lvl0 & 4'b0010, 4'b0000);
      if (e == 6) begin chk("b1_lvl", lvl0, 4'b0010); chk("b1_prs", prs0, 4'b0010); end
      if (e == 7) chk("b1_prs_single", prs0, 4'b0000);
    end
    raw = 4'b0000;
    for (int e = 1; e <= 7; e++) begin
      tick();
      if (e < 6)  chk("b1_rel_early", rel0, 4'b0000);
      if (e == 6) begin chk("b1_rel", rel0, 4'b0010); chk("b1_lvl_low", lvl0, 4'b0000); end
      if (e == 7) chk("b1_rel_single", rel0, 4'b0000);
    end
    ack = 4'b0010; tick(); ack = '0;

    // Bounce on bit 0: 1,1,1,0,1,1,1,1 gives exactly one press.
    bseq = 8'b1111_0111;
    npress = 0;
    for (int i = 0; i < 8; i++) begin
      raw[0] = bseq[i];
      tick();
      if (prs0[0]) npress++;
    end
    for (int i = 0; i < 8; i++) begin
      tick();
      if (prs0[0]) npress++;
    end
    chk("bounce_npress", 4'(npress), 4'd1);
    chk("bounce_lvl", lvl0, 4'b0001);
    raw[0] = 1'b0; ticks(8);
    ack = 4'b0001; tick(); ack = '0;

    // Sticky/ack handshake on bit 2.
    raw[2] = 1'b1; ticks(8);
    chk("stk2_set", stk0 & 4'b0100, 4'b0100);
    ack[2] = 1'b1; tick(); ack[2] = 1'b0;
    chk("stk2_ack", stk0 & 4'b0100, 4'b0000);
    raw[2] = 1'b0; ticks(8);
    raw[2] = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin
      tick();
      found = prs0[2];
    end
    chk("press2_seen", {3'b000, found}, 4'b0001);
    ack[2] = 1'b1; tick();
    chk("stk2_set_wins", stk0 & 4'b0100, 4'b0100);
    tick(); ack[2] = 1'b0;
    chk("stk2_ack_held", stk0 & 4'b0100, 4'b0000);
    raw[2] = 1'b0; ticks(8);

    // Inversion: bit 0 of the inverted instance reads pressed when its pin goes low.
    chk("inv_idle", lvl1, 4'b0000);
    raw_i[0] = 1'b0;
    for (int e = 1; e <= 6; e++) begin
      tick();
      if (e < 6)  chk("inv_prs_early", prs1, 4'b0000);
      if (e == 6) chk("inv_prs", prs1, 4'b0001);
    end
    ack_i = 4'b0001; tick(); ack_i = '0;

    // Reset in the middle of bit 3's count discards it; the count restarts afterwards.
    raw[3] = 1'b1;
    ticks(5);
    async_reset();
    @(posedge clk); #1;
    check_zero("mid_rst");
    rst_n = 1'b1;
    for (int e = 1; e <= 6; e++) begin
      tick();
      if (e < 6)  begin chk("b3_prs_early", prs0, 4'b0000); chk("b3_lvl_early", lvl0, 4'b0000); end
      if (e == 6) begin chk("b3_prs", prs0, 4'b1000); chk("b3_lvl", lvl0, 4'b1000); end
    end

    // Random bouncing buttons and acks on both instances.
    for (int c = 0; c < 600; c++) begin
      for (int b = 0; b < 4; b++) begin
        if ($urandom_range(0, 5) == 0) raw[b]   = ~raw[b];
        if ($urandom_range(0, 5) == 0) raw_i[b] = ~raw_i[b];
        ack[b]   = ($urandom_range(0, 7) == 0);
        ack_i[b] = ($urandom_range(0, 7) == 0);
      end
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/btn_conditioner.md
# btn_conditioner

Conditions the raw Urbana board push-buttons before they reach the MicroBlaze GPIO inputs and the fabric reset/run logic. Per button: a 2-flop synchroniser, a counter-based debouncer, one-cycle press/release pulses, and a sticky press flag with a software acknowledge. It replaces the single-flop `run` capture in the board top level. Its outputs feed the block design's GPIO input channels directly.

## Interface
- `NUM_BTN`, default 4: number of buttons conditioned.
- `DEBOUNCE_CYCLES`, default 1_000_000: stable-sample count required to accept a change (10 ms at 100 MHz); legal range ≥ 2.
- `INVERT_MASK`, default 4'b0000: per-bit mask; a 1 inverts that raw input before synchronisation, for active-low buttons.
- `clk`  in  1: 100 MHz system clock; all state on rising edge.
- `rst_n`  in  1: asynchronous, active-low reset; one clock domain.
- `btn_raw`  in  NUM_BTN: asynchronous button pins.
- `ack`  in  NUM_BTN: per-bit clear of `btn_sticky`, sampled each clock (GPIO output from software).
- `btn_level`  out  NUM_BTN: debounced level, 1 = pressed.
- `btn_press`  out  NUM_BTN: one-cycle pulse on debounced 0→1.
- `btn_release`  out  NUM_BTN: one-cycle pulse on debounced 1→0.
- `btn_sticky`  out  NUM_BTN: set by press, held until acknowledged.

## Operation
- Input stage: `in_i = btn_raw[i] ^ INVERT_MASK[i]` (combinational), then sync1 → sync2 flops. Both reset to 0.
- Per-button debouncer state: `level` (reset 0) and counter `cnt`. Counter width is `$clog2(DEBOUNCE_CYCLES)`. Reset value is 0.
- Each clock, per button:
  - If `sync2 == level`: `cnt <= 0`. Any bounce back to the current level restarts the count.
  - Else if `cnt == DEBOUNCE_CYCLES-1`: `level <= sync2`, `cnt <= 0`, and assert the edge pulse (`btn_press` if `sync2` = 1, else `btn_release`).
  - Else: `cnt <= cnt + 1`.
- `btn_press` and `btn_release` are registered. Each is high for exactly one cycle, coincident with the first cycle of the new `btn_level`. For a given bit they are never both high.
- Sticky flag, per bit:
  - Press pulse condition sets it.
  - `ack` = 1 clears it.
  - Simultaneous set and ack: set wins, flag stays 1.
  - `ack` held high continuously suppresses nothing but the hold; the next press sets the flag again on its edge.
- Buttons are fully independent. No cross-bit interaction.
- Counter never wraps. It is bounded by the accept condition.

## Timing
- Reset (asynchronous assert): `btn_level`, `btn_press`, `btn_release`, `btn_sticky`, sync flops and counters go 0 immediately. Release is used synchronously by downstream logic.
- Latency: a clean raw change first sampled by sync1 at edge E appears on `btn_level`/pulse after edge E + DEBOUNCE_CYCLES + 1. That is 2 sync edges plus DEBOUNCE_CYCLES counting edges, with the first count edge being the sync2 edge.
- A raw glitch shorter than DEBOUNCE_CYCLES cycles, measured at sync2, never changes `btn_level` and produces no pulse.
- A button held through reset release is treated as a new press: it generates `btn_press` and sets `btn_sticky` after the full latency.
- Reset mid-count discards the partial count. No pulse is emitted.
- `ack` to `btn_sticky` clear latency is 1 cycle (clears at the next edge).
- Minimum press-to-press interval is 2·DEBOUNCE_CYCLES cycles (press accept plus release accept).

## Test plan
Use DEBOUNCE_CYCLES = 4 and NUM_BTN = 4 unless stated.
- **Reset values:** drive `btn_raw` = 4'b1111 during reset → all outputs 0 while `rst_n` = 0. After release, `btn_press` = 4'b1111 for one cycle exactly 6 cycles after the first post-reset edge, then `btn_sticky` = 4'b1111.
- **Clean press/release on bit 1:**
  - Raw 0→1 → `btn_level[1]` rises 6 edges after raw change, with `btn_press[1]` a single-cycle pulse.
  - Raw 1→0 → `btn_release[1]` pulse 6 edges later.
  - Other bits stay 0.
- **Bounce rejection:** bit 0 toggled 1,1,1,0,1,1,1,1 (cycle by cycle at sync2) → no change until 4 consecutive 1s accumulate after the 0. Exactly one `btn_press[0]` occurs.
- **Sticky/ack handshake:**
  - Press bit 2 → `btn_sticky[2]` = 1.
  - Pulse `ack[2]` → `btn_sticky[2]` = 0 next cycle.
  - Assert `ack[2]` in the same cycle as a new `btn_press[2]` → `btn_sticky[2]` remains 1.
- **Inversion:** INVERT_MASK = 4'b0001, `btn_raw[0]` held 1 → `btn_level[0]` = 0. Drive it to 0 → `btn_press[0]` after 6 edges.
- **Reset mid-debounce:** raw bit 3 rises, assert `rst_n` = 0 after 3 counting cycles → no pulse. `btn_level[3]` = 0. After release, the count restarts from 0.
